uart_tx_fifo: RTL

Byte FIFO and launch controller that sits directly upstream of the UART transmitter. It accepts bytes from the application side with a write strobe and buffers them in a DEPTH-entry circular buffer. It hands the bytes to the transmitter one at a time using the transmitter's start / tx_data / tx_done handshake. It lets a producer queue a burst of bytes without tracking frame timing.

---
 rtl/uart_tx_fifo.sv | 84 ++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: launches the head byte 2 edges after a write into an idle, empty FIFO.
// Writes are never stalled; a write while full is dropped and flagged by a one-cycle overflow pulse.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_done,
  output logic             busy
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           state, state_nxt;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             wr_accept;
  logic             launch;

  // full is judged on the registered count, so a same-cycle pop never rescues a write
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign wr_accept = wr_en && !full;
  assign busy      = (state != S_IDLE) || !empty;

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          launch    = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tx_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_nxt;
      overflow <= wr_en && full;
      tx_start <= launch;
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (launch) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      case ({wr_accept, launch})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
